// File: rtl/dds_wavegen_if.sv
// Settings and sample bundle for dds_wavegen.
// The master drives settings and enable; the slave returns samples and the wrap strobe.
interface dds_wavegen_if #(
  parameter int PW = 24,
  parameter int OW = 8
);
  logic          en;
  logic          load;
  logic [PW-1:0] fcw;
  logic [PW-1:0] poff;
  logic [1:0]    mode;
  logic [PW-1:0] duty;
  logic [OW-1:0] amp;
  logic [OW-1:0] x;
  logic          x_valid;
  logic          wrap;

  modport master (
    output en, load, fcw, poff, mode, duty, amp,
    input  x, x_valid, wrap
  );

  modport slave (
    input  en, load, fcw, poff, mode, duty, amp,
    output x, x_valid, wrap
  );
endinterface

// File: rtl/dds_wavegen.sv
// Phase-accumulator waveform generator: triangle, rising/falling saw and square output.
// Settings are staged and swapped in at the phase wrap; the output is two registers deep.
module dds_wavegen #(
  parameter int PW = 24,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dds_wavegen_if.slave  bus
);
  typedef enum logic [1:0] {
    MODE_TRI  = 2'd0,
    MODE_RISE = 2'd1,
    MODE_FALL = 2'd2,
    MODE_SQR  = 2'd3
  } mode_t;

  localparam logic [PW-1:0] DUTY_RST = {1'b1, {(PW-1){1'b0}}};
  localparam logic [OW-1:0] AMP_RST  = {OW{1'b1}};
  localparam logic [OW-1:0] W_HIGH   = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] W_LOW    = {1'b1, {(OW-1){1'b0}}};

  logic [PW-1:0] acc_reg;
  logic [PW-1:0] acc_next;
  logic [PW:0]   acc_sum;
  logic          carry;
  logic          wrap_reg;

  logic [PW-1:0] fcw_act_reg,  fcw_act_next;
  logic [PW-1:0] poff_act_reg, poff_act_next;
  logic [PW-1:0] duty_act_reg, duty_act_next;
  mode_t         mode_act_reg, mode_act_next;
  logic [OW-1:0] amp_act_reg,  amp_act_next;

  logic [PW-1:0] fcw_pend_reg,  fcw_pend_next;
  logic [PW-1:0] poff_pend_reg, poff_pend_next;
  logic [PW-1:0] duty_pend_reg, duty_pend_next;
  mode_t         mode_pend_reg, mode_pend_next;
  logic [OW-1:0] amp_pend_reg,  amp_pend_next;
  logic          pend_reg,      pend_next;

  logic [PW-1:0] phase;
  logic [OW-1:0] tri_u;
  logic [OW-1:0] w_next;
  logic [OW-1:0] w_reg;
  logic [OW-1:0] amp_s1_reg;
  logic          v1_reg;

  logic signed [2*OW:0] w_ext;
  logic signed [2*OW:0] amp_ext;
  logic signed [2*OW:0] prod;
  logic [OW-1:0]        x_reg;
  logic                 xv_reg;

  assign acc_sum  = {1'b0, acc_reg} + {1'b0, fcw_act_reg};
  assign carry    = bus.en & acc_sum[PW];
  assign acc_next = bus.en ? acc_sum[PW-1:0] : acc_reg;

  // A load on the carry edge bypasses staging; otherwise pending waits for a
  // carry, or for any edge while the accumulator is stopped.
  always_comb begin
    fcw_act_next   = fcw_act_reg;
    poff_act_next  = poff_act_reg;
    duty_act_next  = duty_act_reg;
    mode_act_next  = mode_act_reg;
    amp_act_next   = amp_act_reg;
    fcw_pend_next  = fcw_pend_reg;
    poff_pend_next = poff_pend_reg;
    duty_pend_next = duty_pend_reg;
    mode_pend_next = mode_pend_reg;
    amp_pend_next  = amp_pend_reg;
    pend_next      = pend_reg;
    if (bus.load && carry) begin
      fcw_act_next  = bus.fcw;
      poff_act_next = bus.poff;
      duty_act_next = bus.duty;
      mode_act_next = mode_t'(bus.mode);
      amp_act_next  = bus.amp;
      pend_next     = 1'b0;
    end else if (bus.load) begin
      fcw_pend_next  = bus.fcw;
      poff_pend_next = bus.poff;
      duty_pend_next = bus.duty;
      mode_pend_next = mode_t'(bus.mode);
      amp_pend_next  = bus.amp;
      pend_next      = 1'b1;
    end else if (pend_reg && (carry || !bus.en)) begin
      fcw_act_next  = fcw_pend_reg;
      poff_act_next = poff_pend_reg;
      duty_act_next = duty_pend_reg;
      mode_act_next = mode_pend_reg;
      amp_act_next  = amp_pend_reg;
      pend_next     = 1'b0;
    end
  end

  assign phase = acc_reg + poff_act_reg;

  // Triangle fold: the top phase bit mirrors the second half of the period.
  genvar gi;
  generate
    for (gi = 0; gi < OW; gi++) begin : g_fold
      assign tri_u[gi] = phase[PW-OW-1+gi] ^ phase[PW-1];
    end
  endgenerate

  always_comb begin
    w_next = W_LOW;
    case (mode_act_reg)
      MODE_TRI:  w_next = {~tri_u[OW-1], tri_u[OW-2:0]};
      MODE_RISE: w_next = {~phase[PW-1], phase[PW-2:PW-OW]};
      MODE_FALL: w_next = ~{~phase[PW-1], phase[PW-2:PW-OW]};
      MODE_SQR:  w_next = (phase < duty_act_reg) ? W_HIGH : W_LOW;
      default:   w_next = W_LOW;
    endcase
  end

  // Gain travels with its sample so a wrap-edge swap never mixes old shape with new amp.
  always_comb begin
    w_ext   = $signed({{(OW+1){w_reg[OW-1]}}, w_reg});
    amp_ext = $signed({{(OW+1){1'b0}}, amp_s1_reg});
    prod    = w_ext * amp_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      wrap_reg      <= 1'b0;
      fcw_act_reg   <= '0;
      poff_act_reg  <= '0;
      duty_act_reg  <= DUTY_RST;
      mode_act_reg  <= MODE_TRI;
      amp_act_reg   <= AMP_RST;
      fcw_pend_reg  <= '0;
      poff_pend_reg <= '0;
      duty_pend_reg <= '0;
      mode_pend_reg <= MODE_TRI;
      amp_pend_reg  <= '0;
      pend_reg      <= 1'b0;
      w_reg         <= '0;
      amp_s1_reg    <= '0;
      v1_reg        <= 1'b0;
      x_reg         <= '0;
      xv_reg        <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      wrap_reg      <= carry;
      fcw_act_reg   <= fcw_act_next;
      poff_act_reg  <= poff_act_next;
      duty_act_reg  <= duty_act_next;
      mode_act_reg  <= mode_act_next;
      amp_act_reg   <= amp_act_next;
      fcw_pend_reg  <= fcw_pend_next;
      poff_pend_reg <= poff_pend_next;
      duty_pend_reg <= duty_pend_next;
      mode_pend_reg <= mode_pend_next;
      amp_pend_reg  <= amp_pend_next;
      pend_reg      <= pend_next;
      v1_reg        <= bus.en;
      if (bus.en) begin
        w_reg      <= w_next;
        amp_s1_reg <= amp_act_reg;
      end
      xv_reg <= v1_reg;
      if (v1_reg) begin
        x_reg <= OW'(prod >>> OW);
      end
    end
  end

  assign bus.x       = x_reg;
  assign bus.x_valid = xv_reg;
  assign bus.wrap    = wrap_reg;
endmodule

// File: tb/tb_dds_wavegen.sv
// Randomised and directed bench for dds_wavegen against a cycle-level arithmetic model.
module tb_dds_wavegen;
  localparam int     PW  = 24;
  localparam int     OW  = 8;
  localparam longint MOD = 64'd1 << PW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dds_wavegen_if #(.PW(PW), .OW(OW)) bif ();

  dds_wavegen #(.PW(PW), .OW(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Model state: active and pending settings, accumulator, one sample in flight.
  longint m_acc, m_fcw, m_poff, m_duty;
  int     m_mode, m_amp;
  longint p_fcw, p_poff, p_duty;
  int     p_mode, p_amp;
  bit     m_pend;
  bit     prev_en;
  int     prev_s;
  int     exp_x;
  bit     exp_xv, exp_wrap;
  int     xmin, xmax;

  function automatic int wave(input longint p, input int md, input longint du);
    longint q;
    longint u;
    case (md)
      0: begin
        q = p >> (PW - OW - 1);
        u = (q < (64'd1 << OW)) ? q : ((64'd1 << (OW + 1)) - 1 - q);
        return int'(u) - (1 << (OW - 1));
      end
      1: return int'(p >> (PW - OW)) - (1 << (OW - 1));
      2: return (1 << (OW - 1)) - 1 - int'(p >> (PW - OW));
      default: return (p < du) ? (1 << (OW - 1)) - 1 : -(1 << (OW - 1));
    endcase
  endfunction

  function automatic int sample(input longint acc, input longint po, input int md,
                                input longint du, input int am);
    int w;
    w = wave((acc + po) % MOD, md, du);
    return (w * am) >>> OW;
  endfunction

  function automatic longint sx();
    return longint'($signed(bif.x));
  endfunction

  task automatic tick();
    bit carry;
    int s;
    @(posedge clk);
    if (!rst_n) begin
      m_acc = 0; m_fcw = 0; m_poff = 0; m_duty = MOD / 2; m_mode = 0; m_amp = (1 << OW) - 1;
      m_pend = 0; prev_en = 0; prev_s = 0; exp_x = 0; exp_xv = 0; exp_wrap = 0;
    end else begin
      carry    = bif.en && (m_acc + m_fcw >= MOD);
      s        = sample(m_acc, m_poff, m_mode, m_duty, m_amp);
      exp_xv   = prev_en;
      if (prev_en) exp_x = prev_s;
      prev_en  = bif.en;
      prev_s   = s;
      exp_wrap = carry;
      if (bif.en) m_acc = (m_acc + m_fcw) % MOD;
      if (bif.load && carry) begin
        m_fcw = bif.fcw; m_poff = bif.poff; m_duty = bif.duty; m_mode = bif.mode; m_amp = bif.amp;
        m_pend = 0;
      end else if (bif.load) begin
        p_fcw = bif.fcw; p_poff = bif.poff; p_duty = bif.duty; p_mode = bif.mode; p_amp = bif.amp;
        m_pend = 1;
      end else if (m_pend && (carry || !bif.en)) begin
        m_fcw = p_fcw; m_poff = p_poff; m_duty = p_duty; m_mode = p_mode; m_amp = p_amp;
        m_pend = 0;
      end
    end
    #1;
    check_eq("x", sx(), exp_x);
    check_eq("x_valid", bif.x_valid, exp_xv);
    check_eq("wrap", bif.wrap, exp_wrap);
    if (bif.x_valid) begin
      if (sx() < xmin) xmin = int'(sx());
      if (sx() > xmax) xmax = int'(sx());
    end
  endtask

  task automatic load_cfg(input longint f, input longint po, input int md,
                          input longint du, input int am);
    bif.fcw  = PW'(f);
    bif.poff = PW'(po);
    bif.mode = 2'(md);
    bif.duty = PW'(du);
    bif.amp  = OW'(am);
    bif.load = 1'b1;
    tick();
    bif.load = 1'b0;
  endtask

  task automatic wait_wrap(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bif.wrap && n < limit);
    if (!bif.wrap) check_eq("wrap_timeout", n, -1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n1, n2, hi, lo, wraps;
    bif.en = 1'b0; bif.load = 1'b0; bif.fcw = '0; bif.poff = '0;
    bif.mode = '0; bif.duty = '0; bif.amp = '0;
    xmin = 1000; xmax = -1000;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_x", sx(), 0);
    check_eq("rst_x_valid", bif.x_valid, 0);
    check_eq("rst_wrap", bif.wrap, 0);

    // Triangle period and valid latency
    load_cfg(6698, 0, 0, MOD / 2, 255);
    tick();
    bif.en = 1'b1;
    tick();
    check_eq("t1_xv_early", bif.x_valid, 0);
    tick();
    check_eq("t1_xv_rise", bif.x_valid, 1);
    xmin = 1000; xmax = -1000;
    wait_wrap(3000, n1);
    wait_wrap(3000, n2);
    check_eq("t1_period", (n2 == 2504 || n2 == 2505), 1);
    check_eq("t1_xmin", xmin, -128);
    check_eq("t1_xmax", xmax, 126);

    // Rising saw exact values
    bif.en = 1'b0;
    do_reset();
    load_cfg(65536, 0, 1, MOD / 2, 255);
    tick();
    bif.en = 1'b1;
    tick();
    tick();
    check_eq("t2_first", sx(), -128);
    tick();
    check_eq("t2_second", sx(), -127);
    tick();
    check_eq("t2_third", sx(), -126);
    wait_wrap(400, n1);
    xmin = 1000; xmax = -1000;
    wait_wrap(400, n2);
    check_eq("t2_period", n2, 256);
    check_eq("t2_top", xmax, 126);

    // Square at 25% duty
    load_cfg(65536, 0, 3, 4194304, 255);
    wait_wrap(400, n1);
    wait_wrap(400, n1);
    hi = 0; lo = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (sx() == 126) hi++;
      if (sx() == -128) lo++;
    end
    check_eq("t3_high", hi, 64);
    check_eq("t3_low", lo, 192);

    // Retune mid-period, then a load on the wrap edge
    load_cfg(65536, 0, 1, MOD / 2, 255);
    wait_wrap(400, n1);
    repeat (100) tick();
    load_cfg(131072, 0, 1, MOD / 2, 255);
    wait_wrap(400, n1);
    check_eq("t4_old_slope", 101 + n1, 256);
    wait_wrap(400, n2);
    check_eq("t4_new_period", n2, 128);
    repeat (127) tick();
    load_cfg(65536, 0, 1, MOD / 2, 255);
    check_eq("t4_wrap_coincide", bif.wrap, 1);
    wait_wrap(400, n1);
    check_eq("t4_direct_apply", n1, 256);

    // Falling saw, amplitude
    load_cfg(65536, 0, 2, MOD / 2, 0);
    wait_wrap(400, n1);
    tick();
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sx() != 0) hi++;
    end
    check_eq("t5_silent", hi, 0);
    load_cfg(65536, 0, 2, MOD / 2, 128);
    wait_wrap(400, n1);
    tick();
    tick();
    check_eq("t5_first", sx(), 63);
    tick();
    check_eq("t5_second", sx(), 63);
    tick();
    check_eq("t5_third", sx(), 62);

    // Reset mid-operation discards pending settings
    repeat (37) tick();
    load_cfg(12345, 777, 3, 100, 200);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t6_x", sx(), 0);
    check_eq("t6_xv", bif.x_valid, 0);
    check_eq("t6_wrap", bif.wrap, 0);
    bif.en = 1'b0;
    tick();
    tick();
    bif.en = 1'b1;
    tick();
    tick();
    check_eq("t6_default_x", sx(), -128);
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bif.wrap) wraps++;
    end
    check_eq("t6_no_wrap", wraps, 0);

    // Random settings, enables, loads and occasional reset
    for (int i = 0; i < 3000; i++) begin
      bif.en   = ($urandom_range(0, 9) != 0);
      bif.load = ($urandom_range(0, 24) == 0);
      if (bif.load) begin
        case ($urandom_range(0, 3))
          0: bif.fcw = PW'($urandom);
          1: bif.fcw = PW'($urandom_range(0, 255));
          default: bif.fcw = PW'($urandom_range(0, 1 << 20));
        endcase
        bif.poff = PW'($urandom);
        bif.mode = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: bif.duty = '0;
          1: bif.duty = '1;
          default: bif.duty = PW'($urandom);
        endcase
        bif.amp = OW'($urandom);
      end
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n    = 1'b1;
    bif.load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
